// File: rtl/regfile_write_arbiter.sv
// Merges WB writeback, EPC save and UART receive onto one register-file port.
// Define UART_WORD_ASSEMBLE_EN to pack four UART bytes into one 32-bit write.
module regfile_write_arbiter #(
    parameter logic [4:0]  UART_REG0    = 5'd4,
    parameter logic [4:0]  UART_REG1    = 5'd5,
    parameter logic [4:0]  EPC_REG      = 5'd26,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wb_reg_write,
    input  logic [4:0]  wb_write_register,
    input  logic [31:0] wb_write_data,
    input  logic        exc_valid,
    input  logic [31:0] exc_epc,
    output logic        exc_ready,
    input  logic        uart_signal,
    input  logic        uart_flag,
    input  logic [7:0]  uart_rx_data,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic [1:0]  grant_src,
    output logic        starve_stall,
    output logic        uart_overflow
);
    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    logic             exc_pending_q, exc_pending_d;
    logic [31:0]      exc_data_q, exc_data_d;
    logic [1:0]       fcnt_q, fcnt_d, fcnt_pop;
    logic [1:0][4:0]  faddr_q, faddr_d;
    logic [1:0][31:0] fdata_q, fdata_d;
    logic [7:0]       starve_q, starve_d;
    logic             stall_q, stall_d;
    logic             ovf_q, ovf_d;

    logic        wb_gnt, exc_gnt, uart_gnt, buf_gnt, buffered;
    logic        push_req, push_ok;
    logic [4:0]  push_addr;
    logic [31:0] push_data;

    assign wb_gnt    = wb_reg_write && (wb_write_register != 5'd0);
    assign exc_gnt   = !wb_gnt && exc_pending_q;
    assign uart_gnt  = !wb_gnt && !exc_pending_q && (fcnt_q != 2'd0);
    assign buf_gnt   = exc_gnt || uart_gnt;
    assign buffered  = exc_pending_q || (fcnt_q != 2'd0);
    assign push_addr = uart_flag ? UART_REG1 : UART_REG0;

    assign exc_ready     = ~exc_pending_q;
    assign starve_stall  = stall_q;
    assign uart_overflow = ovf_q;

    always_comb begin
        rf_we     = 1'b0;
        rf_waddr  = 5'd0;
        rf_wdata  = 32'd0;
        grant_src = 2'b00;
        if (!reset) begin
            if (wb_gnt) begin
                rf_we     = 1'b1;
                rf_waddr  = wb_write_register;
                rf_wdata  = wb_write_data;
                grant_src = 2'b01;
            end else if (exc_gnt) begin
                rf_we     = 1'b1;
                rf_waddr  = EPC_REG;
                rf_wdata  = exc_data_q;
                grant_src = 2'b10;
            end else if (uart_gnt) begin
                rf_we     = 1'b1;
                rf_waddr  = faddr_q[0];
                rf_wdata  = fdata_q[0];
                grant_src = 2'b11;
            end
        end
    end

`ifdef UART_WORD_ASSEMBLE_EN
    logic [31:0] acc_q, acc_d;
    logic [1:0]  bcnt_q, bcnt_d;
    logic        flag_q, flag_d;

    // Bytes shift in from the top so the first byte ends up in [7:0].
    always_comb begin
        acc_d     = acc_q;
        bcnt_d    = bcnt_q;
        flag_d    = flag_q;
        push_req  = 1'b0;
        push_data = {uart_rx_data, acc_q[31:8]};
        if (uart_signal) begin
            flag_d = uart_flag;
            if (bcnt_q != 2'd0 && uart_flag != flag_q) begin
                acc_d  = {uart_rx_data, 24'd0};
                bcnt_d = 2'd1;
            end else if (bcnt_q == 2'd3) begin
                push_req = 1'b1;
                bcnt_d   = 2'd0;
            end else begin
                acc_d  = {uart_rx_data, acc_q[31:8]};
                bcnt_d = bcnt_q + 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q  <= 32'd0;
            bcnt_q <= 2'd0;
            flag_q <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            bcnt_q <= bcnt_d;
            flag_q <= flag_d;
        end
    end
`else
    assign push_req  = uart_signal;
    assign push_data = {24'd0, uart_rx_data};
`endif

    always_comb begin
        exc_pending_d = exc_pending_q;
        exc_data_d    = exc_data_q;
        if (exc_gnt) exc_pending_d = 1'b0;
        if (exc_valid && exc_ready) begin
            exc_pending_d = 1'b1;
            exc_data_d    = exc_epc;
        end
    end

    // A full FIFO still takes a push when its head retires this cycle.
    assign push_ok  = push_req && (fcnt_q != 2'd2 || uart_gnt);
    assign fcnt_pop = fcnt_q - {1'b0, uart_gnt};

    always_comb begin
        faddr_d = faddr_q;
        fdata_d = fdata_q;
        if (uart_gnt) begin
            faddr_d[0] = faddr_q[1];
            fdata_d[0] = fdata_q[1];
        end
        if (push_ok) begin
            faddr_d[fcnt_pop[0]] = push_addr;
            fdata_d[fcnt_pop[0]] = push_data;
        end
        fcnt_d = fcnt_pop + {1'b0, push_ok};
        ovf_d  = ovf_q | (push_req & ~push_ok);
    end

    always_comb begin
        starve_d = starve_q;
        if (buf_gnt || !buffered) starve_d = 8'd0;
        else if (starve_q != LIMIT) starve_d = starve_q + 8'd1;
        stall_d = buf_gnt ? 1'b0 : (stall_q || starve_d == LIMIT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            exc_pending_q <= 1'b0;
            exc_data_q    <= 32'd0;
            fcnt_q        <= 2'd0;
            faddr_q       <= '0;
            fdata_q       <= '0;
            starve_q      <= 8'd0;
            stall_q       <= 1'b0;
            ovf_q         <= 1'b0;
        end else begin
            exc_pending_q <= exc_pending_d;
            exc_data_q    <= exc_data_d;
            fcnt_q        <= fcnt_d;
            faddr_q       <= faddr_d;
            fdata_q       <= fdata_d;
            starve_q      <= starve_d;
            stall_q       <= stall_d;
            ovf_q         <= ovf_d;
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: queue-based reference model plus
// directed scenarios and a randomized run.
module tb_regfile_write_arbiter;
    localparam int LIMIT = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        wb_reg_write;
    logic [4:0]  wb_write_register;
    logic [31:0] wb_write_data;
    logic        exc_valid;
    logic [31:0] exc_epc;
    logic        exc_ready;
    logic        uart_signal;
    logic        uart_flag;
    logic [7:0]  uart_rx_data;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [1:0]  grant_src;
    logic        starve_stall;
    logic        uart_overflow;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    regfile_write_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk(clk),
        .reset(reset),
        .wb_reg_write(wb_reg_write),
        .wb_write_register(wb_write_register),
        .wb_write_data(wb_write_data),
        .exc_valid(exc_valid),
        .exc_epc(exc_epc),
        .exc_ready(exc_ready),
        .uart_signal(uart_signal),
        .uart_flag(uart_flag),
        .uart_rx_data(uart_rx_data),
        .rf_we(rf_we),
        .rf_waddr(rf_waddr),
        .rf_wdata(rf_wdata),
        .grant_src(grant_src),
        .starve_stall(starve_stall),
        .uart_overflow(uart_overflow)
    );

    // Reference model state: pending work as queues, plain counters.
    logic [31:0] exc_q[$];
    logic [36:0] uq[$];
    logic [7:0]  m_bytes[$];
    bit          m_flag;
    int          m_cnt;
    bit          m_stall;
    bit          m_ovf;

    function automatic logic [42:0] model_expect();
        logic        we;
        logic [4:0]  a;
        logic [31:0] d;
        logic [1:0]  s;
        logic        rdy;
        we = 0; a = 0; d = 0; s = 0;
        rdy = (exc_q.size() == 0);
        if (!reset) begin
            if (wb_reg_write && wb_write_register != 0) begin
                we = 1; a = wb_write_register;
                d = wb_write_data; s = 2'b01;
            end else if (exc_q.size() > 0) begin
                we = 1; a = 5'd26; d = exc_q[0]; s = 2'b10;
            end else if (uq.size() > 0) begin
                we = 1; a = uq[0][36:32];
                d = uq[0][31:0]; s = 2'b11;
            end
        end
        return {we, a, d, s, rdy, m_stall, m_ovf};
    endfunction

    task automatic model_push(input logic [36:0] e, input bit popped,
                              input int usz);
        if (usz < 2 || popped) uq.push_back(e);
        else m_ovf = 1;
    endtask

    task automatic model_commit();
        bit wbg, eg, ug, buffered, rdy;
        int usz;
        logic [4:0] sel;
        wbg = wb_reg_write && wb_write_register != 0;
        eg  = !wbg && exc_q.size() > 0;
        ug  = !wbg && exc_q.size() == 0 && uq.size() > 0;
        buffered = exc_q.size() > 0 || uq.size() > 0;
        rdy = exc_q.size() == 0;
        usz = uq.size();
        sel = uart_flag ? 5'd5 : 5'd4;
        if (reset) begin
            exc_q.delete(); uq.delete(); m_bytes.delete();
            m_flag = 0; m_cnt = 0; m_stall = 0; m_ovf = 0;
            return;
        end
        if (eg || ug || !buffered) m_cnt = 0;
        else if (m_cnt < LIMIT) m_cnt++;
        if (eg || ug) m_stall = 0;
        else if (m_cnt == LIMIT) m_stall = 1;
        if (eg) void'(exc_q.pop_front());
        if (ug) void'(uq.pop_front());
        if (exc_valid && rdy) exc_q.push_back(exc_epc);
        if (uart_signal) begin
`ifdef UART_WORD_ASSEMBLE_EN
            if (m_bytes.size() > 0 && uart_flag != m_flag)
                m_bytes.delete();
            m_flag = uart_flag;
            m_bytes.push_back(uart_rx_data);
            if (m_bytes.size() == 4) begin
                model_push({sel, m_bytes[3], m_bytes[2],
                            m_bytes[1], m_bytes[0]}, ug, usz);
                m_bytes.delete();
            end
`else
            model_push({sel, 24'd0, uart_rx_data}, ug, usz);
`endif
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_commit();
        #1;
    endtask

    task automatic idle_inputs();
        wb_reg_write = 0; wb_write_register = 0; wb_write_data = 0;
        exc_valid = 0; exc_epc = 0;
        uart_signal = 0; uart_flag = 0; uart_rx_data = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1;
        tick();
        tick();
        reset = 0;
    endtask

    function automatic logic [42:0] observed();
        return {rf_we, rf_waddr, rf_wdata, grant_src,
                exc_ready, starve_stall, uart_overflow};
    endfunction

    task automatic test_reset();
        logic [42:0] got, exp;
        idle_inputs();
        reset = 1;
        tick();
        for (int i = 0; i < 3; i++) begin
            wb_reg_write = 1; wb_write_register = 5'($urandom_range(1, 31));
            wb_write_data = $urandom; exc_valid = 1; exc_epc = $urandom;
            uart_signal = 1; uart_rx_data = 8'($urandom);
            #2;
            got = observed(); exp = model_expect();
            checks++;
            if (got[42:3] !== 40'd0 || got !== exp) begin
                errors++;
                $display("FAIL reset_outputs: got %h want %h", got, exp);
            end
            tick();
        end
        reset = 0; idle_inputs();
        #2;
        checks++;
        if ({exc_ready, starve_stall, uart_overflow, rf_we} !== 4'b1000) begin
            errors++;
            $display("FAIL reset_state: rdy=%b stall=%b ovf=%b we=%b want 1000",
                     exc_ready, starve_stall, uart_overflow, rf_we);
        end
        tick();
    endtask

    task automatic test_wb_basic();
        do_reset();
        wb_reg_write = 1; wb_write_register = 5'd8;
        wb_write_data = 32'hDEADBEEF;
        #2;
        checks++;
        if ({rf_we, rf_waddr, rf_wdata, grant_src} !==
            {1'b1, 5'd8, 32'hDEADBEEF, 2'b01}) begin
            errors++;
            $display("FAIL wb_basic: we=%b a=%0d d=%h src=%b want 1 8 deadbeef 01",
                     rf_we, rf_waddr, rf_wdata, grant_src);
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_exc_latency();
        logic [42:0] got, exp;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            wb_reg_write = 1; wb_write_register = 5'd9;
            wb_write_data = $urandom;
            exc_valid = (i == 0); exc_epc = 32'h00400010;
            #2;
            got = observed(); exp = model_expect();
            checks++;
            if (got !== exp || (i > 0 && exc_ready !== 1'b0)) begin
                errors++;
                $display("FAIL exc_busy[%0d]: got %h want %h rdy=%b",
                         i, got, exp, exc_ready);
            end
            tick();
        end
        idle_inputs();
        #2;
        checks++;
        if ({rf_we, rf_waddr, rf_wdata, grant_src} !==
            {1'b1, 5'd26, 32'h00400010, 2'b10}) begin
            errors++;
            $display("FAIL exc_retire: we=%b a=%0d d=%h src=%b want 1 26 00400010 10",
                     rf_we, rf_waddr, rf_wdata, grant_src);
        end
        tick();
        #2;
        checks++;
        if (exc_ready !== 1'b1 || rf_we !== 1'b0) begin
            errors++;
            $display("FAIL exc_ready_rise: rdy=%b we=%b want 1 0", exc_ready, rf_we);
        end
        tick();
    endtask

    task automatic test_exc_uart_same_cycle();
        logic [42:0] got, exp;
        do_reset();
        exc_valid = 1; exc_epc = 32'h8000_0180;
        uart_signal = 1; uart_flag = 0; uart_rx_data = 8'h41;
        for (int i = 0; i < 4; i++) begin
            #2;
            got = observed(); exp = model_expect();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL exc_uart[%0d]: got %h want %h", i, got, exp);
            end
`ifndef UART_WORD_ASSEMBLE_EN
            if (i == 1 || i == 2) begin
                checks++;
                if ((i == 1 && {grant_src, rf_waddr} !== {2'b10, 5'd26}) ||
                    (i == 2 && {grant_src, rf_waddr, rf_wdata} !==
                     {2'b11, 5'd4, 32'h41})) begin
                    errors++;
                    $display("FAIL exc_uart_order[%0d]: src=%b a=%0d d=%h",
                             i, grant_src, rf_waddr, rf_wdata);
                end
            end
`endif
            tick();
            idle_inputs();
        end
    endtask

    task automatic test_overflow_starve();
        logic [42:0] got, exp;
        do_reset();
        for (int i = 0; i < 13; i++) begin
            wb_reg_write = 1;
            wb_write_register = 5'($urandom_range(1, 31));
            wb_write_data = $urandom;
            uart_signal = (i < 3); uart_flag = (i == 1);
            uart_rx_data = 8'(8'hA0 + i);
            #2;
            got = observed(); exp = model_expect();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL ovf_busy[%0d]: got %h want %h", i, got, exp);
            end
            tick();
        end
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            #2;
            got = observed(); exp = model_expect();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL ovf_drain[%0d]: got %h want %h", i, got, exp);
            end
`ifndef UART_WORD_ASSEMBLE_EN
            checks++;
            if ((i == 0 && {grant_src, rf_waddr, rf_wdata, starve_stall,
                            uart_overflow} !== {2'b11, 5'd4, 32'hA0, 2'b11}) ||
                (i == 1 && {grant_src, rf_waddr, rf_wdata} !==
                 {2'b11, 5'd5, 32'hA1}) ||
                (i == 2 && {rf_we, starve_stall, uart_overflow} !== 3'b001)) begin
                errors++;
                $display("FAIL ovf_directed[%0d]: src=%b a=%0d d=%h stall=%b ovf=%b",
                         i, grant_src, rf_waddr, rf_wdata,
                         starve_stall, uart_overflow);
            end
`endif
            tick();
        end
    endtask

    task automatic test_wb_zero();
        logic [42:0] got, exp;
        do_reset();
        wb_reg_write = 1; wb_write_register = 5'd7; wb_write_data = $urandom;
        uart_signal = 1; uart_flag = 1; uart_rx_data = 8'h5A;
        tick();
        idle_inputs();
        wb_reg_write = 1; wb_write_register = 5'd0; wb_write_data = $urandom;
        #2;
        got = observed(); exp = model_expect();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL wb_zero_model: got %h want %h", got, exp);
        end
`ifndef UART_WORD_ASSEMBLE_EN
        checks++;
        if ({grant_src, rf_waddr, rf_wdata} !== {2'b11, 5'd5, 32'h5A}) begin
            errors++;
            $display("FAIL wb_zero: src=%b a=%0d d=%h want 11 5 0000005a",
                     grant_src, rf_waddr, rf_wdata);
        end
`endif
        tick();
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        logic [42:0] got, exp;
        do_reset();
        for (int i = 0; i < 2; i++) begin
            wb_reg_write = 1; wb_write_register = 5'd3; wb_write_data = $urandom;
            exc_valid = 1; exc_epc = $urandom;
            uart_signal = 1; uart_rx_data = 8'($urandom);
            tick();
        end
        idle_inputs();
        reset = 1;
        #2;
        checks++;
        if ({rf_we, grant_src} !== 3'b000) begin
            errors++;
            $display("FAIL reset_mid_hold: we=%b src=%b want 0 00", rf_we, grant_src);
        end
        tick();
        reset = 0;
        #2;
        got = observed(); exp = model_expect();
        checks++;
        if (got !== exp || {rf_we, exc_ready} !== 2'b01) begin
            errors++;
            $display("FAIL reset_mid_clear: got %h want %h", got, exp);
        end
        tick();
    endtask

    task automatic test_random();
        logic [42:0] got, exp;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 99) < 2);
            wb_reg_write = ($urandom_range(0, 99) < 60);
            wb_write_register = ($urandom_range(0, 4) == 0) ? 5'd0
                                : 5'($urandom);
            wb_write_data = $urandom;
            exc_valid = ($urandom_range(0, 99) < 20);
            exc_epc = $urandom;
            uart_signal = ($urandom_range(0, 99) < 35);
            uart_flag = ($urandom_range(0, 9) == 0) ? ~uart_flag : uart_flag;
            uart_rx_data = 8'($urandom);
            #2;
            got = observed(); exp = model_expect();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL random[%0d]: got %h want %h", i, got, exp);
            end
            tick();
        end
        reset = 0;
        idle_inputs();
    endtask

`ifdef UART_WORD_ASSEMBLE_EN
    task automatic test_word_assemble();
        logic [7:0] bytes[6];
        logic       flags[6];
        int         writes;
        bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        flags = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        writes = 0;
        do_reset();
        for (int i = 0; i < 9; i++) begin
            idle_inputs();
            if (i < 6) begin
                uart_signal = 1; uart_flag = flags[i]; uart_rx_data = bytes[i];
            end
            #2;
            if (rf_we === 1'b1) writes++;
            if (i == 6) begin
                checks++;
                if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd5, 32'h66554433}) begin
                    errors++;
                    $display("FAIL word_assemble: we=%b a=%0d d=%h want 1 5 66554433",
                             rf_we, rf_waddr, rf_wdata);
                end
            end
            tick();
        end
        checks++;
        if (writes != 1) begin
            errors++;
            $display("FAIL word_assemble_count: got %0d writes want 1", writes);
        end
    endtask
`endif

    initial begin
        idle_inputs();
        reset = 1;
        m_flag = 0; m_cnt = 0; m_stall = 0; m_ovf = 0;
        test_reset();
        test_wb_basic();
        test_exc_latency();
        test_exc_uart_same_cycle();
        test_overflow_starve();
        test_wb_zero();
        test_reset_mid();
        test_random();
`ifdef UART_WORD_ASSEMBLE_EN
        test_word_assemble();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Single-write-port arbiter for the register file. It merges three write sources into one port: WB-stage writeback, exception/interrupt EPC save to $26 (k0), and UART receive data into two fixed registers. Writeback is never delayed. Exception and UART writes are buffered and retired in idle WB slots. A starvation counter asks the hazard logic for bubbles when buffered writes cannot find a free slot. The block sits between the WB stage, the interrupt logic, the UART receiver and the RegisterFile write port.

## Interface
- `UART_REG0`, 5'd4: target register when `uart_flag`=0.
- `UART_REG1`, 5'd5: target register when `uart_flag`=1.
- `EPC_REG`, 5'd26: target register for exception saves.
- `STARVE_LIMIT`, 8: waiting cycles before `starve_stall` is raised (range 1–255).
- `clk` in 1: clock; everything is on the rising edge.
- `reset` in 1: synchronous, active-high.
- `wb_reg_write` in 1: WB write request.
- `wb_write_register` in 5: WB target register.
- `wb_write_data` in 32: WB data.
- `exc_valid` in 1: exception save request.
- `exc_epc` in 32: EPC value to store.
- `exc_ready` out 1: exception buffer empty; a request is accepted when `exc_valid && exc_ready`.
- `uart_signal` in 1: one-cycle pulse, new byte present.
- `uart_flag` in 1: selects `UART_REG0` or `UART_REG1`.
- `uart_rx_data` in 8: received byte.
- `rf_we` out 1: register file write enable.
- `rf_waddr` out 5: register file write address.
- `rf_wdata` out 32: register file write data.
- `grant_src` out 2: source of the current write: 00 none, 01 WB, 10 EXC, 11 UART.
- `starve_stall` out 1: registered request to the hazard unit to insert an ID/EX bubble.
- `uart_overflow` out 1: sticky flag, UART entry dropped.

## Operation
- **WB path.** Priority: WB > EXC > UART.
  - WB is granted whenever `wb_reg_write=1` and `wb_write_register≠0`.
  - A WB write to $0 is dropped and does not occupy the port.
- **Exception buffer (1 entry).**
  - `exc_ready = ~exc_pending`.
  - On accept, the entry {`EPC_REG`, `exc_epc`} is stored.
  - The entry is retired when the port is not taken by WB.
- **UART FIFO (2 entries of {addr, data}).**
  - Each push without `UART_WORD_ASSEMBLE_EN` is {sel reg, `{24'b0, uart_rx_data}`}.
  - The head entry is retired when neither WB nor the exception buffer is granted.
- **FIFO overflow.**
  - A push is accepted if the FIFO is not full, or if it is full and the head pops in the same cycle.
  - Otherwise the push is dropped and `uart_overflow` is set to 1 until reset.
- **Starvation counter (8 bit).**
  - Increments each cycle a buffered entry (EXC or UART) exists and no buffered grant occurs.
  - Clears on any buffered grant or when no entry is buffered.
  - `starve_stall` is set when the counter reaches `STARVE_LIMIT`. It holds until the cycle after a buffered grant, then clears.
  - The counter saturates at `STARVE_LIMIT`.
- **Reset values.**
  - Buffers and FIFO empty, counter 0, `uart_overflow` 0, `starve_stall` 0, `exc_ready` 1.
  - `rf_we`, `rf_waddr`, `rf_wdata` and `grant_src` are all 0 while `reset` is high, regardless of inputs.

## Timing
- `rf_we`, `rf_waddr`, `rf_wdata` and `grant_src` are combinational from `wb_*` and registered buffer state.
  - WB has zero added latency; the RegisterFile writes at the same edge as without the arbiter.
- Exception latency: accept at edge N, write at earliest edge N+1.
  - `exc_ready` falls in the cycle after the accept.
  - `exc_ready` rises in the cycle after the retiring write.
- UART latency: push at edge N, write at earliest edge N+1.
- Simultaneous accept of an exception and a UART push: both are stored. The exception write retires first.
- Reset asserted mid-operation clears all buffered entries; they are not written.

## Configuration
- **Macro `UART_WORD_ASSEMBLE_EN`.**
- **When defined:**
  - Bytes are accumulated little-endian in a 32-bit shift register with a 2-bit byte counter; the first byte goes to [7:0].
  - The 4th byte pushes the whole word.
  - A change of `uart_flag` mid-word discards the partial word and starts a new one with the current byte as byte 0.
  - Reset clears the counter and the accumulator.
- **When undefined:** every byte is pushed immediately, zero-extended.

## Test plan
- Reset, then `wb_reg_write=1`, reg 8, data 0xDEADBEEF in one cycle -> same cycle `rf_we=1`, `rf_waddr=8`, `rf_wdata=0xDEADBEEF`, `grant_src=01`.
- `exc_valid` with `exc_epc=0x00400010` while WB writes for 3 cycles -> `exc_ready=0` from the next cycle; write $26=0x00400010 in the first WB-idle cycle; `exc_ready=1` the cycle after.
- Exception and UART byte 0x41 (`flag=0`) in the same cycle, WB idle -> $26 written at N+1, $4=0x00000041 at N+2.
- Three UART bytes while WB is continuously busy -> third byte dropped, `uart_overflow=1`; with `STARVE_LIMIT=8`, `starve_stall=1` after 8 waiting cycles; after WB goes idle, two writes occur and `starve_stall` clears.
- WB write to $0 with a UART entry pending -> UART entry granted in the same cycle (`grant_src=11`).
- With `UART_WORD_ASSEMBLE_EN`, bytes 0x11, 0x22, `flag` toggles, then 0x33, 0x44, 0x55, 0x66 -> single write $5=0x66554433.
